// File: rtl/fetch_req_tracker_pkg.sv
// Shared constants and helpers for the fetch request tracker.
// Exception codes mirror the CP0 encoding; entry layout and reset-PC default live here.
package fetch_req_tracker_pkg;

    localparam int          PC_W             = 32;
    localparam int          INST_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'hbfc00000;

    // CP0 Cause.ExcCode for an address error on load / instruction fetch.
    localparam logic [4:0]  EXC_ADEL         = 5'h04;

    // Fetches must be word aligned; anything else raises AdEL without touching the sram.
    function automatic logic pc_misaligned(input logic [PC_W-1:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_req_tracker_if.sv
// Bundles the sram-like instruction port and the in-order delivery port towards IF.
// master: the tracker side. slave: the sram plus IF side.
interface fetch_req_tracker_if;

    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_exception;
    logic [4:0]  out_exccode;

    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        output out_valid, out_pc, out_inst, out_exception, out_exccode,
        input  out_ready
    );

    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
        input  out_valid, out_pc, out_inst, out_exception, out_exccode,
        output out_ready
    );

endinterface

// File: rtl/fetch_req_tracker_entry_queue.sv
// Ordered entry store for the fetch tracker: tail allocates, resp completes, head pops.
// resp always points at the oldest entry still waiting for data_ok (or at tail when none
// is waiting); exception entries are born done, so resp steps over them.
module fetch_req_tracker_entry_queue
    import fetch_req_tracker_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc,
    input  logic [PC_W-1:0]   alloc_pc,
    input  logic              alloc_exc,
    input  logic              complete,
    input  logic [INST_W-1:0] complete_inst,
    input  logic              pop,
    input  logic              flush,
    output logic [PC_W-1:0]   head_pc,
    output logic [INST_W-1:0] head_inst,
    output logic              head_done,
    output logic              head_discard,
    output logic              head_exc,
    output logic              full,
    output logic [PTR_W:0]    occupancy
);

    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [PC_W-1:0]   pc_mem   [0:DEPTH-1];
    logic [INST_W-1:0] inst_mem [0:DEPTH-1];
    logic [DEPTH-1:0]  done_q;
    logic [DEPTH-1:0]  discard_q;
    logic [DEPTH-1:0]  exc_q;
    logic [PTR_W-1:0]  head_q;
    logic [PTR_W-1:0]  tail_q;
    logic [PTR_W-1:0]  resp_q;
    logic [PTR_W:0]    count_q;

    logic              has_pending;
    logic              complete_ok;
    logic [PTR_W-1:0]  resp_age;
    logic [PTR_W:0]    resp_span;
    logic [PTR_W-1:0]  cand;
    logic              scan_found;
    logic [PTR_W-1:0]  scan_idx;
    logic [PTR_W-1:0]  resp_base;
    logic [PTR_W-1:0]  resp_next;

    assign head_pc      = pc_mem[head_q];
    assign head_inst    = inst_mem[head_q];
    assign head_done    = done_q[head_q];
    assign head_discard = discard_q[head_q];
    assign head_exc     = exc_q[head_q];
    assign full         = (count_q == FULL_COUNT);
    assign occupancy    = count_q;
    assign complete_ok  = complete && has_pending;

    // Locate the next entry that will await data once the current resp entry completes.
    always_comb begin
        resp_age    = resp_q - head_q;
        resp_span   = count_q - {1'b0, resp_age};
        has_pending = (resp_q != tail_q) || (full && !done_q[resp_q]);
        cand        = resp_q;
        scan_found  = 1'b0;
        scan_idx    = tail_q;
        for (int k = 1; k < DEPTH; k++) begin
            cand = resp_q + PTR_W'(k);
            if (!scan_found && ((PTR_W+1)'(k) < resp_span) && !done_q[cand]) begin
                scan_found = 1'b1;
                scan_idx   = cand;
            end
        end
        resp_base = complete_ok ? scan_idx : resp_q;
        // A freshly allocated exception entry never awaits data, so resp must not land on it.
        resp_next = (alloc && alloc_exc && (resp_base == tail_q)) ? (tail_q + PTR_ONE) : resp_base;
    end

    // Pointer, occupancy and per-entry flag bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            resp_q    <= '0;
            count_q   <= '0;
            done_q    <= '0;
            discard_q <= '0;
            exc_q     <= '0;
        end else begin
            if (alloc) begin
                done_q[tail_q]    <= alloc_exc;
                exc_q[tail_q]     <= alloc_exc;
                discard_q[tail_q] <= flush;
                tail_q            <= tail_q + PTR_ONE;
            end
            if (complete_ok) begin
                done_q[resp_q] <= 1'b1;
            end
            if (pop) begin
                head_q <= head_q + PTR_ONE;
            end
            if (flush) begin
                discard_q <= '1;
            end
            resp_q  <= resp_next;
            count_q <= count_q + (PTR_W+1)'(alloc) - (PTR_W+1)'(pop);
        end
    end

    // Entry payload storage; only the flags need a reset.
    always_ff @(posedge clk) begin
        if (alloc) begin
            pc_mem[tail_q]   <= alloc_pc;
            inst_mem[tail_q] <= '0;
        end
        if (complete_ok) begin
            inst_mem[resp_q] <= complete_inst;
        end
    end

    // data_ok with nothing outstanding means the sram side broke the protocol.
    always_ff @(posedge clk) begin
        if (!reset && complete) begin
            assert (has_pending) else $error("inst_sram_data_ok with no outstanding fetch");
        end
    end

endmodule

// File: rtl/fetch_req_tracker.sv
// Fetch request tracker: generates fetch PCs, issues sram-like reads with up to DEPTH
// entries live, and delivers results to IF in order. A redirect tags live entries as
// discard instead of waiting for them. Optional macro FETCH_TRACKER_STATS_EN adds the
// stat_discarded / stat_full_cycles perf counters.
module fetch_req_tracker
    import fetch_req_tracker_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    localparam int         PTR_W    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    fetch_req_tracker_if.master bus,
    output logic [PTR_W:0]      occupancy
`ifdef FETCH_TRACKER_STATS_EN
    ,
    output logic [31:0]         stat_discarded,
    output logic [31:0]         stat_full_cycles
`endif
);

    logic [31:0] pc_q;
    logic        stall_q;
    logic        can_issue;
    logic        pc_aligned;
    logic        alloc;
    logic        alloc_exc;
    logic        pop;
    logic        q_full;
    logic [31:0] head_pc;
    logic [31:0] head_inst;
    logic        head_done;
    logic        head_discard;
    logic        head_exc;
    logic        head_live;

    // Issue is blocked while full (registered count, so a pop only helps next cycle),
    // during a redirect, and after a misaligned PC until the next redirect.
    assign can_issue  = !reset && !redirect_valid && !q_full && !stall_q;
    assign pc_aligned = !pc_misaligned(pc_q);

    assign bus.inst_sram_req  = can_issue && pc_aligned;
    assign bus.inst_sram_wr   = 1'b0;
    assign bus.inst_sram_size = 2'd2;
    assign bus.inst_sram_addr = pc_q;

    assign alloc     = (bus.inst_sram_req && bus.inst_sram_addr_ok) || (can_issue && !pc_aligned);
    assign alloc_exc = !pc_aligned;

    assign head_live         = (occupancy != '0);
    assign bus.out_valid     = head_live && head_done && !head_discard && !redirect_valid;
    assign bus.out_pc        = head_pc;
    assign bus.out_inst      = head_exc ? 32'd0 : head_inst;
    assign bus.out_exception = head_exc;
    assign bus.out_exccode   = head_exc ? EXC_ADEL : 5'd0;

    // Discarded entries leave as soon as they are done; live ones wait for IF.
    assign pop = head_live && head_done && (head_discard || (bus.out_valid && bus.out_ready));

    // Fetch PC and misaligned-stall tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            stall_q <= 1'b0;
        end else if (redirect_valid) begin
            pc_q    <= redirect_pc;
            stall_q <= 1'b0;
        end else if (bus.inst_sram_req && bus.inst_sram_addr_ok) begin
            pc_q <= pc_q + 32'd4;
        end else if (can_issue && !pc_aligned) begin
            stall_q <= 1'b1;
        end
    end

    fetch_req_tracker_entry_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk           (clk),
        .reset         (reset),
        .alloc         (alloc),
        .alloc_pc      (pc_q),
        .alloc_exc     (alloc_exc),
        .complete      (bus.inst_sram_data_ok),
        .complete_inst (bus.inst_sram_rdata),
        .pop           (pop),
        .flush         (redirect_valid),
        .head_pc       (head_pc),
        .head_inst     (head_inst),
        .head_done     (head_done),
        .head_discard  (head_discard),
        .head_exc      (head_exc),
        .full          (q_full),
        .occupancy     (occupancy)
    );

`ifdef FETCH_TRACKER_STATS_EN
    logic silent_pop;
    assign silent_pop = pop && head_discard;

    // Free-running perf counters: silent discards and cycles spent full.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_discarded   <= 32'd0;
            stat_full_cycles <= 32'd0;
        end else begin
            if (silent_pop) begin
                stat_discarded <= stat_discarded + 32'd1;
            end
            if (q_full) begin
                stat_full_cycles <= stat_full_cycles + 32'd1;
            end
        end
    end
`else
    // Perf counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_req_tracker.sv
// Self-checking bench for fetch_req_tracker: a hand-derived vector table, directed
// multi-cycle sequences and randomized traffic checked against a queue-based model.
module tb_fetch_req_tracker;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [2:0]  occupancy;
`ifdef FETCH_TRACKER_STATS_EN
    logic [31:0] stat_discarded;
    logic [31:0] stat_full_cycles;
`endif

    fetch_req_tracker_if ifc ();

    fetch_req_tracker #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'hbfc00000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (ifc),
        .occupancy      (occupancy)
`ifdef FETCH_TRACKER_STATS_EN
        ,
        .stat_discarded   (stat_discarded),
        .stat_full_cycles (stat_full_cycles)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          done;
        bit          disc;
        bit          exc;
    } ment_t;

    typedef struct {
        logic [31:0] addr;
        int          t;
    } rsp_t;

    ment_t       mq[$];
    rsp_t        rq[$];
    logic [31:0] m_pc;
    bit          m_stall;
    int          cyc;
    int          lat;
    int          m_disc;
    int          m_full;
    int          n_aok;
    int          aok_at_first_dok;
    bit          got_dok;
    bit          first_cap;
    logic [31:0] first_pc;
    int          stale_seen;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9e3779b1) ^ 32'h0badf00d;
    endfunction

    task automatic model_reset();
        mq.delete();
        rq.delete();
        m_pc    = 32'hbfc00000;
        m_stall = 0;
        cyc     = 0;
        m_disc  = 0;
        m_full  = 0;
    endtask

    task automatic idle_inputs();
        redirect_valid        = 1'b0;
        redirect_pc           = 32'd0;
        ifc.inst_sram_addr_ok = 1'b0;
        ifc.inst_sram_data_ok = 1'b0;
        ifc.inst_sram_rdata   = 32'd0;
        ifc.out_ready         = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", {31'd0, ifc.inst_sram_req}, 32'd0);
        chk("rst_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("rst_occ", {29'd0, occupancy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    // One cycle: drive at negedge, sample 1ns later, advance the model.
    task automatic step(input bit redir, input logic [31:0] rpc, input bit aok,
                        input bit dok_en, input bit ordy);
        bit exp_req, exp_exc_alloc, exp_valid, dok, pop;
        int pre_size;
        @(negedge clk);
        dok = dok_en && (rq.size() > 0) && ((cyc - rq[0].t) >= lat);
        redirect_valid        = redir;
        redirect_pc           = rpc;
        ifc.inst_sram_addr_ok = aok;
        ifc.inst_sram_data_ok = dok;
        ifc.inst_sram_rdata   = dok ? mem_word(rq[0].addr) : 32'hdeadbeef;
        ifc.out_ready         = ordy;
        #1;
        pre_size      = mq.size();
        exp_req       = (pre_size < DEPTH) && !redir && (m_pc[1:0] == 2'b00) && !m_stall;
        exp_exc_alloc = (pre_size < DEPTH) && !redir && (m_pc[1:0] != 2'b00) && !m_stall;
        exp_valid     = (pre_size > 0) && mq[0].done && !mq[0].disc && !redir;

        chk("req", {31'd0, ifc.inst_sram_req}, {31'd0, exp_req});
        if (exp_req) chk("addr", ifc.inst_sram_addr, m_pc);
        chk("valid", {31'd0, ifc.out_valid}, {31'd0, exp_valid});
        chk("occ", {29'd0, occupancy}, pre_size);
        if (exp_valid) begin
            chk("out_pc", ifc.out_pc, mq[0].pc);
            chk("out_inst", ifc.out_inst, mq[0].exc ? 32'd0 : mq[0].inst);
            chk("out_exc", {31'd0, ifc.out_exception}, {31'd0, mq[0].exc});
            if (mq[0].exc) chk("exccode", {27'd0, ifc.out_exccode}, 32'd4);
        end
`ifdef FETCH_TRACKER_STATS_EN
        chk("stat_disc", stat_discarded, m_disc);
        chk("stat_full", stat_full_cycles, m_full);
`endif
        if (ifc.out_valid && ordy && !first_cap) begin
            first_cap = 1;
            first_pc  = ifc.out_pc;
        end
        if (ifc.out_valid && ifc.out_pc[31:28] == 4'hb) stale_seen++;
        if (dok && !got_dok) begin
            got_dok          = 1;
            aok_at_first_dok = n_aok;
        end

        if (pre_size == DEPTH) m_full++;
        pop = (pre_size > 0) && mq[0].done && (mq[0].disc || (exp_valid && ordy));
        if (dok) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (!mq[i].done) begin
                    mq[i].inst = mem_word(rq[0].addr);
                    mq[i].done = 1;
                    break;
                end
            end
            void'(rq.pop_front());
        end
        if (pop) begin
            if (mq[0].disc) m_disc++;
            void'(mq.pop_front());
        end
        if (exp_req && aok) begin
            mq.push_back('{pc: m_pc, inst: 32'd0, done: 0, disc: 0, exc: 0});
            rq.push_back('{addr: m_pc, t: cyc});
            m_pc = m_pc + 32'd4;
            n_aok++;
        end else if (exp_exc_alloc) begin
            mq.push_back('{pc: m_pc, inst: 32'd0, done: 1, disc: 0, exc: 1});
            m_stall = 1;
        end
        if (redir) begin
            for (int i = 0; i < mq.size(); i++) mq[i].disc = 1;
            m_pc    = rpc;
            m_stall = 0;
        end
        cyc++;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          redir;
        logic [31:0] rpc;
        bit          aok;
        bit          dok;
        logic [31:0] rdata;
        bit          ordy;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        bit          e_exc;
        logic [2:0]  e_occ;
    } vec_t;

    vec_t vt[14];

    function automatic vec_t mkv(bit redir, logic [31:0] rpc, bit aok, bit dok,
                                 logic [31:0] rdata, bit ordy, bit e_req, logic [31:0] e_addr,
                                 bit e_valid, logic [31:0] e_pc, logic [31:0] e_inst,
                                 bit e_exc, logic [2:0] e_occ);
        vec_t v;
        v.redir = redir; v.rpc = rpc; v.aok = aok; v.dok = dok; v.rdata = rdata; v.ordy = ordy;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
        v.e_inst = e_inst; v.e_exc = e_exc; v.e_occ = e_occ;
        return v;
    endfunction

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        logic [31:0] rpc;
        reset = 1'b1;
        idle_inputs();
        lat = 1;
        first_cap = 0; stale_seen = 0; got_dok = 0; n_aok = 0;

        //    redir rpc           aok dok rdata         rdy  req addr          vld pc            inst          exc occ
        vt[0]  = mkv(0, 32'h0,        1, 0, 32'h0,        1,  1, 32'hbfc00000, 0, 32'h0,        32'h0,        0, 3'd0);
        vt[1]  = mkv(0, 32'h0,        1, 1, 32'h11111111, 1,  1, 32'hbfc00004, 0, 32'h0,        32'h0,        0, 3'd1);
        vt[2]  = mkv(0, 32'h0,        1, 1, 32'h22222222, 1,  1, 32'hbfc00008, 1, 32'hbfc00000, 32'h11111111, 0, 3'd2);
        vt[3]  = mkv(0, 32'h0,        0, 1, 32'h33333333, 1,  1, 32'hbfc0000c, 1, 32'hbfc00004, 32'h22222222, 0, 3'd2);
        vt[4]  = mkv(0, 32'h0,        0, 0, 32'h0,        1,  1, 32'hbfc0000c, 1, 32'hbfc00008, 32'h33333333, 0, 3'd1);
        vt[5]  = mkv(0, 32'h0,        0, 0, 32'h0,        1,  1, 32'hbfc0000c, 0, 32'h0,        32'h0,        0, 3'd0);
        vt[6]  = mkv(1, 32'h80000002, 0, 0, 32'h0,        1,  0, 32'h0,        0, 32'h0,        32'h0,        0, 3'd0);
        vt[7]  = mkv(0, 32'h0,        1, 0, 32'h0,        1,  0, 32'h0,        0, 32'h0,        32'h0,        0, 3'd0);
        vt[8]  = mkv(0, 32'h0,        0, 0, 32'h0,        0,  0, 32'h0,        1, 32'h80000002, 32'h0,        1, 3'd1);
        vt[9]  = mkv(0, 32'h0,        0, 0, 32'h0,        1,  0, 32'h0,        1, 32'h80000002, 32'h0,        1, 3'd1);
        vt[10] = mkv(0, 32'h0,        0, 0, 32'h0,        1,  0, 32'h0,        0, 32'h0,        32'h0,        0, 3'd0);
        vt[11] = mkv(0, 32'h0,        1, 0, 32'h0,        1,  0, 32'h0,        0, 32'h0,        32'h0,        0, 3'd0);
        vt[12] = mkv(1, 32'h80001000, 0, 0, 32'h0,        1,  0, 32'h0,        0, 32'h0,        32'h0,        0, 3'd0);
        vt[13] = mkv(0, 32'h0,        0, 0, 32'h0,        1,  1, 32'h80001000, 0, 32'h0,        32'h0,        0, 3'd0);

        do_reset();
        chk("wr_const", {31'd0, ifc.inst_sram_wr}, 32'd0);
        chk("size_const", {30'd0, ifc.inst_sram_size}, 32'd2);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            redirect_valid        = vt[i].redir;
            redirect_pc           = vt[i].rpc;
            ifc.inst_sram_addr_ok = vt[i].aok;
            ifc.inst_sram_data_ok = vt[i].dok;
            ifc.inst_sram_rdata   = vt[i].rdata;
            ifc.out_ready         = vt[i].ordy;
            #1;
            chk($sformatf("vec%0d_req", i), {31'd0, ifc.inst_sram_req}, {31'd0, vt[i].e_req});
            if (vt[i].e_req) chk($sformatf("vec%0d_addr", i), ifc.inst_sram_addr, vt[i].e_addr);
            chk($sformatf("vec%0d_valid", i), {31'd0, ifc.out_valid}, {31'd0, vt[i].e_valid});
            chk($sformatf("vec%0d_occ", i), {29'd0, occupancy}, {29'd0, vt[i].e_occ});
            if (vt[i].e_valid) begin
                chk($sformatf("vec%0d_pc", i), ifc.out_pc, vt[i].e_pc);
                chk($sformatf("vec%0d_inst", i), ifc.out_inst, vt[i].e_inst);
                chk($sformatf("vec%0d_exc", i), {31'd0, ifc.out_exception}, {31'd0, vt[i].e_exc});
                if (vt[i].e_exc) chk($sformatf("vec%0d_exccode", i), {27'd0, ifc.out_exccode}, 32'd4);
            end
        end

        // Long sram latency: exactly DEPTH requests accepted before the first response.
        do_reset();
        lat = 10; n_aok = 0; got_dok = 0;
        for (int i = 0; i < 40; i++) step(0, 32'd0, 1, 1, 1);
        chk("aok_before_first_dok", got_dok ? aok_at_first_dok : -1, DEPTH);

        // Redirect with three fetches in flight: stale data is dropped silently.
        do_reset();
        lat = 8; first_cap = 0; stale_seen = 0;
        for (int i = 0; i < 3; i++) step(0, 32'd0, 1, 1, 1);
        step(0, 32'd0, 0, 1, 1);
        step(1, 32'h80001000, 0, 1, 1);
        for (int i = 0; i < 30; i++) step(0, 32'd0, 1, 1, 1);
        chk("first_pc_after_redirect", first_cap ? first_pc : 32'hffffffff, 32'h80001000);
        chk("stale_delivered", stale_seen, 0);
`ifdef FETCH_TRACKER_STATS_EN
        chk("stat_discarded_3", stat_discarded, 32'd3);
`endif

        // Backpressure: queue fills, issue stops, payload holds, then drains in order.
        do_reset();
        lat = 1;
        for (int i = 0; i < 20; i++) step(0, 32'd0, 1, 1, 0);
        chk("bp_full_occ", {29'd0, occupancy}, DEPTH);
        chk("bp_full_req", {31'd0, ifc.inst_sram_req}, 32'd0);
        for (int i = 0; i < 20; i++) step(0, 32'd0, 1, 1, 1);

        // Redirect in the same cycle as data_ok and addr_ok.
        do_reset();
        lat = 1;
        step(0, 32'd0, 1, 1, 1);
        step(0, 32'd0, 1, 1, 1);
        step(1, 32'h80002000, 1, 1, 1);
        chk("coinc_no_req", {31'd0, ifc.inst_sram_req}, 32'd0);
        step(0, 32'd0, 0, 1, 1);
        chk("coinc_next_req", {31'd0, ifc.inst_sram_req}, 32'd1);
        chk("coinc_next_addr", ifc.inst_sram_addr, 32'h80002000);
        for (int i = 0; i < 12; i++) step(0, 32'd0, 1, 1, 1);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            bit redir;
            if (i % 500 == 0) lat = $urandom_range(1, 4);
            redir = ($urandom_range(0, 39) == 0);
            rpc   = $urandom & 32'hfffffffc;
            if ($urandom_range(0, 5) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            step(redir, rpc, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_req_tracker.md
Name: fetch_req_tracker

Overview:
Parametrised successor to the single-outstanding pre-IF stage. It generates instruction-fetch PCs and issues sram-like read requests, with up to DEPTH requests in flight. Responses are tracked in an ordered queue and delivered in order to IF under valid/ready backpressure. On a redirect, stale in-flight fetches are discarded by tagging their entries; the block does not stall waiting for them. It sits between the PC-select logic and IF, replacing the discard_instruction single-bit scheme.

Parameters:
DEPTH, 4, max entries (in-flight plus completed-undelivered); power of 2, at least 2.
RESET_PC, 32'hbfc00000, PC fetched first after reset.
PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
redirect_valid  in  1  flush and redirect (exception, eret, branch mispredict)
redirect_pc  in  32  new fetch PC
inst_sram_req  out  1  sram-like request
inst_sram_wr  out  1  constant 0
inst_sram_size  out  2  constant 2'd2
inst_sram_addr  out  32  request address (virtual = physical; translation is external)
inst_sram_addr_ok  in  1  address accepted
inst_sram_data_ok  in  1  data returned (in order)
inst_sram_rdata  in  32  returned instruction
out_valid  out  1  head entry deliverable
out_ready  in  1  IF accepts
out_pc  out  32  PC of delivered entry
out_inst  out  32  instruction (0 when out_exception)
out_exception  out  1  fetch exception on this entry
out_exccode  out  5  `EXC_AdEL when out_exception
occupancy  out  PTR_W+1  live entry count (debug/perf)

Behaviour:
- Reset values: pc=RESET_PC; head, tail and resp pointers=0; occupancy=0; all entry flags=0; inst_sram_req=0; out_valid=0.
- Entry fields: pc[31:0], inst[31:0], done, discard, exc.
- Circular queue with three pointers:
  - tail: allocate.
  - resp: oldest entry awaiting data_ok.
  - head: deliver.
  - Pointers wrap modulo DEPTH; full/empty are distinguished by occupancy.
- Issue when occupancy<DEPTH and !redirect_valid:
  - If pc[1:0]==0: inst_sram_req=1, inst_sram_addr=pc. When addr_ok is seen, allocate tail {pc, done=0, exc=0} and set pc<=pc+4.
  - If pc misaligned: no sram req. Allocate tail {pc, done=1, exc=1} immediately. pc holds; further issue stops until a redirect arrives.
- inst_sram_req is combinational. It may drop without addr_ok (sram-like permits this).
- data_ok: write rdata into the entry at resp, set done=1, advance resp past it.
  - resp skips entries with exc=1; these never await data.
  - data_ok while no pending entry exists is a protocol error; assert in sim.
- Head:
  - If done & !discard: out_valid=1. Pop on out_ready.
  - If done & discard: pop silently in that cycle, out_valid=0.
  - If !done: out_valid=0.
- Redirect: every live entry gets discard=1, including entries allocated, completing or popping in the same cycle. pc<=redirect_pc. No issue this cycle. Next cycle issue resumes at redirect_pc.
- Discarded pending entries keep their slots until data_ok. Issue throughput therefore recovers as old responses drain.
- Same-cycle allocate and pop: occupancy unchanged.
- Full with data_ok and pop in the same cycle: the pop frees the slot only for the next cycle's issue (no combinational credit loop).
- Latency: best case is req/addr_ok in cycle N, data_ok in N+1, out_valid in N+2 (registered entry). There is no comb path rdata->out_inst.
- out_valid, once raised, holds with stable payload until out_ready or redirect.

Optional Feature:
FETCH_TRACKER_STATS_EN:
- Defined: adds outputs stat_discarded[31:0] (count of entries popped silently) and stat_full_cycles[31:0] (cycles with occupancy==DEPTH). Both are reset to 0, wrap at 2^32 and are readable by the perf logic.
- Undefined: neither port nor the counters exist.

Decomposition:
- Exccode constants are reused from cp0.vh.
- fetch_pkg.vh holds entry field widths and the reset-PC default.
- One sub-module, fetch_entry_queue: the pointer and occupancy bookkeeping plus the entry storage, with alloc/complete/pop/flush strobes.
- Issue/PC logic stays in the top.

Test Plan:
- Reset, addr_ok and data_ok each 1 cycle after req, out_ready=1 → out_pc sequence bfc00000, bfc00004, bfc00008 at 1 entry/cycle; occupancy never exceeds 2.
- data_ok delayed 10 cycles, DEPTH=4 → exactly 4 addr_oks, then inst_sram_req=0 until the first data_ok; in-order delivery.
- 3 requests in flight, redirect_pc=80001000 → 3 stale responses produce no out_valid; stat_discarded=3; first delivered out_pc=80001000.
- redirect_pc=80000002 → no sram req; out_valid with out_exception=1, out_exccode=AdEL, out_pc=80000002; issue stalled until the next redirect.
- out_ready=0 for 20 cycles → queue fills to DEPTH, req stops, out_pc/out_inst stable; releases cleanly in order.
- Redirect coincident with data_ok and addr_ok → both entries discarded and no req that cycle; the next req carries redirect_pc.
